// File: rtl/ctrl_mc_if.sv
// Control-unit bus: IR fields, status and memory handshake in; datapath/memory controls out.
// The master modport is the controller side, the slave modport the datapath side.
interface ctrl_mc_if #(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned MM_W   = 4,
    parameter int unsigned STAT_W = 4
);
    logic [OP_W-1:0]   opcode;
    logic [MM_W-1:0]   mm;
    logic [STAT_W-1:0] stat;
    logic              mem_rdy;
    logic              mem_req;
    logic              dm_we;
    logic              ir_load;
    logic              pc_write;
    logic              pc_sel;
    logic              br_sel;
    logic              pc_rst;
    logic [1:0]        alu_op;
    logic              rf_we;
    logic              wb_sel;
    logic              halted;
    logic              mem_err;

    modport master (
        input  opcode, mm, stat, mem_rdy,
        output mem_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst,
               alu_op, rf_we, wb_sel, halted, mem_err
    );

    modport slave (
        output opcode, mm, stat, mem_rdy,
        input  mem_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst,
               alu_op, rf_we, wb_sel, halted, mem_err
    );
endinterface

// File: rtl/ctrl_mc.sv
// Multicycle SISC control FSM with memory wait states, timeout, decode-stage branches and HALT.
// Option: CTRL_FAST_PATH_EN lets ALU/SWP skip the MEM state.
module ctrl_mc #(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned MM_W   = 4,
    parameter int unsigned STAT_W = 4,
    parameter int unsigned AM_IMM = 8,
    parameter int unsigned TMO_W  = 4
) (
    input  logic       clk,
    input  logic       rst_f,
    ctrl_mc_if.master  bus
);
    typedef enum logic [2:0] {
        S_START0, S_START1, S_FETCH, S_DECODE,
        S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [TMO_W-1:0]   r_cnt;
    logic               r_mem_err;
    logic               w_tmo;

    logic w_lod, w_str, w_swp, w_alu, w_hlt, w_bra, w_brr, w_bne, w_bnr;
    logic w_cond, w_branch, w_taken, w_memop;
    logic [1:0] w_alu_op;

    assign w_lod    = (bus.opcode == OP_W'(1));
    assign w_str    = (bus.opcode == OP_W'(2));
    assign w_swp    = (bus.opcode == OP_W'(3));
    assign w_bra    = (bus.opcode == OP_W'(4));
    assign w_brr    = (bus.opcode == OP_W'(5));
    assign w_bne    = (bus.opcode == OP_W'(6));
    assign w_bnr    = (bus.opcode == OP_W'(7));
    assign w_alu    = (bus.opcode == OP_W'(8));
    assign w_hlt    = (bus.opcode == OP_W'(15));
    assign w_memop  = w_lod | w_str;
    assign w_cond   = |(bus.stat & bus.mm);
    assign w_branch = w_bra | w_brr | w_bne | w_bnr;
    assign w_taken  = ((w_bra | w_brr) & w_cond) | ((w_bne | w_bnr) & ~w_cond);

    always_comb begin
        w_alu_op = 2'b00;
        if (w_alu)
            w_alu_op = (bus.mm == MM_W'(AM_IMM)) ? 2'b01 : 2'b00;
        else if (w_memop)
            w_alu_op = 2'b10;
        else if (w_swp)
            w_alu_op = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state   <= S_START0;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counter restarts on every state change; it only advances while waiting on memory.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_FETCH || r_state == S_MEM)
                r_cnt <= r_cnt + TMO_W'(1);
            else
                r_cnt <= '0;
            if (w_tmo)
                r_mem_err <= 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_tmo        = 1'b0;
        bus.mem_req  = 1'b0;
        bus.dm_we    = 1'b0;
        bus.ir_load  = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.br_sel   = 1'b0;
        bus.pc_rst   = 1'b0;
        bus.alu_op   = 2'b00;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.halted   = 1'b0;
        bus.mem_err  = r_mem_err;
        unique case (r_state)
            S_START0: begin
                bus.pc_rst = 1'b1;
                w_next     = S_START1;
            end
            S_START1: begin
                bus.pc_rst = 1'b1;
                w_next     = S_FETCH;
            end
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_rdy) begin
                    bus.ir_load  = 1'b1;
                    bus.pc_write = 1'b1;
                    w_next       = S_DECODE;
                end else if (r_cnt == '1) begin
                    w_tmo  = 1'b1;
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                if (w_hlt)
                    w_next = S_HALT;
                else if (w_branch) begin
                    bus.pc_write = w_taken;
                    bus.pc_sel   = w_taken;
                    bus.br_sel   = w_taken & (w_brr | w_bnr);
                    w_next       = S_FETCH;
                end else if (w_memop | w_swp | w_alu)
                    w_next = S_EXECUTE;
                else
                    w_next = S_FETCH;
            end
            S_EXECUTE: begin
                bus.alu_op = w_alu_op;
`ifdef CTRL_FAST_PATH_EN
                w_next = (w_alu | w_swp) ? S_WRITEBACK : S_MEM;
`else
                w_next = S_MEM;
`endif
            end
            S_MEM: begin
                bus.alu_op = w_alu_op;
                if (w_memop) begin
                    bus.mem_req = 1'b1;
                    bus.dm_we   = w_str;
                    if (bus.mem_rdy)
                        w_next = w_lod ? S_WRITEBACK : S_FETCH;
                    else if (r_cnt == '1) begin
                        w_tmo  = 1'b1;
                        w_next = S_HALT;
                    end
                end else
                    w_next = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                bus.alu_op = w_alu_op;
                bus.rf_we  = w_alu | w_lod | w_swp;
                bus.wb_sel = w_lod;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: w_next = S_START0;
        endcase
    end
endmodule

// File: tb/tb_ctrl_mc.sv
// Bench for ctrl_mc: per-cycle expected output vectors from a table and hand sequences,
// queued as they are driven and checked against the outputs at the falling edge.
module tb_ctrl_mc;
    localparam logic [12:0] MREQ  = 13'h1000;
    localparam logic [12:0] DMWE  = 13'h0800;
    localparam logic [12:0] IRL   = 13'h0400;
    localparam logic [12:0] PCW   = 13'h0200;
    localparam logic [12:0] PCSEL = 13'h0100;
    localparam logic [12:0] BRSEL = 13'h0080;
    localparam logic [12:0] PCRST = 13'h0040;
    localparam logic [12:0] A01   = 13'h0010;
    localparam logic [12:0] A10   = 13'h0020;
    localparam logic [12:0] A11   = 13'h0030;
    localparam logic [12:0] RFWE  = 13'h0008;
    localparam logic [12:0] WBSEL = 13'h0004;
    localparam logic [12:0] HALT  = 13'h0002;
    localparam logic [12:0] MERR  = 13'h0001;
    localparam logic [12:0] F     = MREQ | IRL | PCW;
    localparam logic [12:0] Z     = 13'h0000;

    typedef struct {
        logic [3:0]        op;
        logic [3:0]        mm;
        logic [3:0]        st;
        int unsigned       len;
        logic [4:0][12:0]  exp;
        string             name;
    } rec_t;

    typedef struct {
        logic [12:0] exp;
        string       name;
    } sb_t;

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    int   total = 0;
    int   bad = 0;
    sb_t  sb[$];
    rec_t tbl[13];

    always #5 clk = ~clk;

    ctrl_mc_if #(.OP_W(4), .MM_W(4), .STAT_W(4)) bus ();

    ctrl_mc #(.OP_W(4), .MM_W(4), .STAT_W(4), .AM_IMM(8), .TMO_W(4)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus.master)
    );

    function automatic logic [12:0] outs();
        return {bus.mem_req, bus.dm_we, bus.ir_load, bus.pc_write, bus.pc_sel, bus.br_sel,
                bus.pc_rst, bus.alu_op, bus.rf_we, bus.wb_sel, bus.halted, bus.mem_err};
    endfunction

    function automatic rec_t mk(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st,
                                input int unsigned len, input logic [12:0] e0, input logic [12:0] e1,
                                input logic [12:0] e2, input logic [12:0] e3, input logic [12:0] e4,
                                input string name);
        rec_t r;
        r.op = op; r.mm = mm; r.st = st; r.len = len;
        r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2; r.exp[3] = e3; r.exp[4] = e4;
        r.name = name;
        return r;
    endfunction

    // Called at posedge+1: drive mem_rdy, queue the expectation, check it at the falling edge.
    task automatic step(input logic [12:0] exp, input logic rdy, input string name);
        sb_t e;
        sb_t got;
        logic [12:0] act;
        bus.mem_rdy = rdy;
        e.exp = exp;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        act = outs();
        got = sb.pop_front();
        total++;
        if (act !== got.exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", got.name, act, got.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        step(PCRST, 1'b1, "rst_low0");
        step(PCRST, 1'b1, "rst_low1");
        rst_f = 1'b1;
        step(PCRST, 1'b1, "start0");
        step(PCRST, 1'b1, "start1");
    endtask

    task automatic set_ir(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st);
        bus.opcode = op;
        bus.mm     = mm;
        bus.stat   = st;
    endtask

    initial begin
`ifdef CTRL_FAST_PATH_EN
        tbl[0] = mk(4'd8, 4'd8, 4'd0, 4, F, Z, A01, A01 | RFWE, Z, "alu_imm");
        tbl[1] = mk(4'd8, 4'd3, 4'd0, 4, F, Z, Z, RFWE, Z, "alu_reg");
        tbl[4] = mk(4'd3, 4'd0, 4'd0, 4, F, Z, A11, A11 | RFWE, Z, "swp");
`else
        tbl[0] = mk(4'd8, 4'd8, 4'd0, 5, F, Z, A01, A01, A01 | RFWE, "alu_imm");
        tbl[1] = mk(4'd8, 4'd3, 4'd0, 5, F, Z, Z, Z, RFWE, "alu_reg");
        tbl[4] = mk(4'd3, 4'd0, 4'd0, 5, F, Z, A11, A11, A11 | RFWE, "swp");
`endif
        tbl[2]  = mk(4'd1, 4'd0, 4'd0, 5, F, Z, A10, A10 | MREQ, A10 | RFWE | WBSEL, "lod");
        tbl[3]  = mk(4'd2, 4'd0, 4'd0, 4, F, Z, A10, A10 | MREQ | DMWE, Z, "str");
        tbl[5]  = mk(4'd0, 4'd0, 4'd0, 2, F, Z, Z, Z, Z, "noop");
        tbl[6]  = mk(4'd4, 4'd2, 4'd2, 2, F, PCW | PCSEL, Z, Z, Z, "bra_taken");
        tbl[7]  = mk(4'd4, 4'd4, 4'd2, 2, F, Z, Z, Z, Z, "bra_not");
        tbl[8]  = mk(4'd5, 4'd2, 4'd2, 2, F, PCW | PCSEL | BRSEL, Z, Z, Z, "brr_taken");
        tbl[9]  = mk(4'd6, 4'd2, 4'd2, 2, F, Z, Z, Z, Z, "bne_not");
        tbl[10] = mk(4'd6, 4'd15, 4'd0, 2, F, PCW | PCSEL, Z, Z, Z, "bne_taken");
        tbl[11] = mk(4'd7, 4'd2, 4'd1, 2, F, PCW | PCSEL | BRSEL, Z, Z, Z, "bnr_taken");
        tbl[12] = mk(4'd10, 4'd0, 4'd0, 2, F, Z, Z, Z, Z, "undef_op");

        set_ir(4'd0, 4'd0, 4'd0);
        bus.mem_rdy = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        foreach (tbl[i]) begin
            set_ir(tbl[i].op, tbl[i].mm, tbl[i].st);
            for (int unsigned c = 0; c < tbl[i].len; c++)
                step(tbl[i].exp[c], 1'b1, $sformatf("%s_c%0d", tbl[i].name, c));
        end

        // Fetch wait, then LOD with three MEM wait states.
        set_ir(4'd1, 4'd0, 4'd0);
        step(MREQ, 1'b0, "fetch_wait0");
        step(MREQ, 1'b0, "fetch_wait1");
        step(F, 1'b1, "fetch_done");
        step(Z, 1'b1, "lodw_dec");
        step(A10, 1'b1, "lodw_exe");
        for (int k = 0; k < 3; k++)
            step(A10 | MREQ, 1'b0, $sformatf("lodw_mem_wait%0d", k));
        step(A10 | MREQ, 1'b1, "lodw_mem_rdy");
        step(A10 | RFWE | WBSEL, 1'b1, "lodw_wb");

        // Ready arriving on the limit cycle completes normally.
        step(F, 1'b1, "lim_fetch");
        step(Z, 1'b1, "lim_dec");
        step(A10, 1'b1, "lim_exe");
        for (int k = 0; k < 15; k++)
            step(A10 | MREQ, 1'b0, $sformatf("lim_wait%0d", k));
        step(A10 | MREQ, 1'b1, "lim_rdy_on_limit");
        step(A10 | RFWE | WBSEL, 1'b1, "lim_wb_no_err");

        // HLT holds regardless of inputs.
        set_ir(4'd15, 4'd0, 4'd0);
        step(F, 1'b1, "hlt_fetch");
        step(Z, 1'b1, "hlt_dec");
        step(HALT, 1'b1, "halt0");
        set_ir(4'd1, 4'd0, 4'd0);
        step(HALT, 1'b0, "halt1");
        step(HALT, 1'b1, "halt2");

        // Reset asserted during a STR memory wait drops the request at once.
        do_reset();
        set_ir(4'd2, 4'd0, 4'd0);
        step(F, 1'b1, "rstw_fetch");
        step(Z, 1'b1, "rstw_dec");
        step(A10, 1'b1, "rstw_exe");
        step(A10 | MREQ | DMWE, 1'b0, "rstw_wait0");
        step(A10 | MREQ | DMWE, 1'b0, "rstw_wait1");
        rst_f = 1'b0;
        step(PCRST, 1'b0, "rstw_mid_reset");
        rst_f = 1'b1;
        step(PCRST, 1'b1, "rstw_start0");
        step(PCRST, 1'b1, "rstw_start1");

        // STR with memory never ready: timeout after the counter reaches its limit.
        step(F, 1'b1, "tmo_fetch");
        step(Z, 1'b1, "tmo_dec");
        step(A10, 1'b1, "tmo_exe");
        for (int k = 0; k < 16; k++)
            step(A10 | MREQ | DMWE, 1'b0, $sformatf("tmo_wait%0d", k));
        step(HALT | MERR, 1'b0, "tmo_halt0");
        step(HALT | MERR, 1'b1, "tmo_halt1");

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
